// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read-side scheduler.
package axi_rd_pkg;

  localparam int unsigned ID_W     = 4;
  localparam int unsigned SIZE_W   = 2;
  localparam int unsigned ARSIZE_W = 3;
  localparam int unsigned CNT_W    = 3;

  localparam logic [ID_W-1:0] ID_INST = 4'd0;
  localparam logic [ID_W-1:0] ID_DATA = 4'd1;

  typedef enum logic [0:0] {
    StIdle,
    StReq
  } ar_state_e;

  function automatic logic [ARSIZE_W-1:0] to_arsize(input logic [SIZE_W-1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// Requester and AXI AR/R signals of the read scheduler, grouped as one bundle.
interface axi_read_arbiter_if;
   import axi_rd_pkg::*;

   logic                inst_req;
   logic [31:0]         inst_addr;
   logic [SIZE_W-1:0]   inst_size;
   logic                inst_addr_ok;
   logic                inst_data_ok;
   logic [31:0]         inst_rdata;

   logic                data_req;
   logic [31:0]         data_addr;
   logic [SIZE_W-1:0]   data_size;
   logic                data_addr_ok;
   logic                data_data_ok;
   logic [31:0]         data_rdata;

   logic                wr_busy;
   logic [31:0]         wr_addr;

   logic [ID_W-1:0]     arid;
   logic [31:0]         araddr;
   logic [ARSIZE_W-1:0] arsize;
   logic                arvalid;
   logic                arready;

   logic [ID_W-1:0]     rid;
   logic [31:0]         rdata;
   logic                rvalid;
   logic                rready;

   modport master (
      input  inst_req, inst_addr, inst_size, data_req, data_addr, data_size,
      input  wr_busy, wr_addr, arready, rid, rdata, rvalid,
      output inst_addr_ok, inst_data_ok, inst_rdata,
      output data_addr_ok, data_data_ok, data_rdata,
      output arid, araddr, arsize, arvalid, rready
   );

   modport slave (
      output inst_req, inst_addr, inst_size, data_req, data_addr, data_size,
      output wr_busy, wr_addr, arready, rid, rdata, rvalid,
      input  inst_addr_ok, inst_data_ok, inst_rdata,
      input  data_addr_ok, data_data_ok, data_rdata,
      input  arid, araddr, arsize, arvalid, rready
   );

endinterface

// File: rtl/rd_outstanding_cnt.sv
// Saturating outstanding-read counter for one requester ID.
module rd_outstanding_cnt
   import axi_rd_pkg::*;
#(
   parameter int unsigned MAX = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   localparam logic [CNT_W-1:0] MaxC = CNT_W'(MAX);

   logic [CNT_W-1:0] count_q, count_d;

   // Simultaneous inc/dec cancel; a dec at zero (stray beat) is absorbed.
   always_comb begin
      count_d = count_q;
      if (inc && !dec && count_q < MaxC) begin
         count_d = count_q + 3'd1;
      end else if (dec && !inc && count_q != '0) begin
         count_d = count_q - 3'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign full  = (count_q >= MaxC);

endmodule

// File: rtl/axi_read_arbiter.sv
// Fixed-priority fetch/load scheduler onto one AXI AR/R pair, with per-ID
// outstanding limits and a read-after-write hold on loads.
module axi_read_arbiter
   import axi_rd_pkg::*;
#(
   parameter int unsigned MAX_OUT = 2
) (
   input  logic                aclk,
   input  logic                aresetn,
   axi_read_arbiter_if.master  bus
);

   ar_state_e           state_q, state_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [31:0]         addr_q, addr_d;
   logic [ARSIZE_W-1:0] size_q, size_d;

   logic grant_inst, grant_data;
   logic inst_full, data_full;
   logic raw_block, inst_elig, data_elig;
   logic beat;
   logic [CNT_W-1:0] inst_count, data_count;

   // A load to the word of an uncompleted store must wait for the write path.
   assign raw_block = bus.wr_busy && (bus.wr_addr[31:2] == bus.data_addr[31:2]);
   assign data_elig = bus.data_req && !data_full && !raw_block;
   assign inst_elig = bus.inst_req && !inst_full;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      addr_d     = addr_q;
      size_d     = size_q;
      grant_inst = 1'b0;
      grant_data = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (aresetn && data_elig) begin
               grant_data = 1'b1;
               id_d       = ID_DATA;
               addr_d     = bus.data_addr;
               size_d     = to_arsize(bus.data_size);
               state_d    = StReq;
            end else if (aresetn && inst_elig) begin
               grant_inst = 1'b1;
               id_d       = ID_INST;
               addr_d     = bus.inst_addr;
               size_d     = to_arsize(bus.inst_size);
               state_d    = StReq;
            end
         end
         StReq: begin
            if (bus.arready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= StIdle;
         id_q    <= '0;
         addr_q  <= '0;
         size_q  <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   assign bus.inst_addr_ok = grant_inst;
   assign bus.data_addr_ok = grant_data;
   assign bus.arvalid      = (state_q == StReq);
   assign bus.arid         = id_q;
   assign bus.araddr       = addr_q;
   assign bus.arsize       = size_q;

   // R is always accepted; unknown IDs are drained without touching counters.
   assign bus.rready       = aresetn;
   assign beat             = bus.rvalid && bus.rready;
   assign bus.inst_data_ok = beat && (bus.rid == ID_INST);
   assign bus.data_data_ok = beat && (bus.rid == ID_DATA);
   assign bus.inst_rdata   = bus.rdata;
   assign bus.data_rdata   = bus.rdata;

   rd_outstanding_cnt #(
      .MAX (MAX_OUT)
   ) u_inst_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .inc   (grant_inst),
      .dec   (bus.inst_data_ok),
      .count (inst_count),
      .full  (inst_full)
   );

   rd_outstanding_cnt #(
      .MAX (MAX_OUT)
   ) u_data_cnt (
      .clk   (aclk),
      .rst_n (aresetn),
      .inc   (grant_data),
      .dec   (bus.data_data_ok),
      .count (data_count),
      .full  (data_full)
   );

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomized and directed bench for axi_read_arbiter against a queue-free
// transaction-level model of grants, outstanding counts and R routing.
module tb_axi_read_arbiter;
   import axi_rd_pkg::*;

   localparam int MAX_OUT = 2;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;

   axi_read_arbiter_if bus ();

   axi_read_arbiter #(
      .MAX_OUT (MAX_OUT)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   always #5 aclk = ~aclk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail < 60) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: one pending AR slot plus an integer count per requester.
   bit          m_pend, n_pend;
   logic [3:0]  m_id, n_id;
   logic [31:0] m_addr, n_addr;
   logic [2:0]  m_size, n_size;
   int          m_cnt[2], n_cnt[2];
   bit          checks_on = 0;

   initial begin
      n_pend = 0; n_id = 0; n_addr = 0; n_size = 0;
      n_cnt[0] = 0; n_cnt[1] = 0;
   end

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_pend = 0; m_id = 0; m_addr = 0; m_size = 0;
         m_cnt[0] = 0; m_cnt[1] = 0;
      end else begin
         m_pend = n_pend; m_id = n_id; m_addr = n_addr; m_size = n_size;
         m_cnt[0] = n_cnt[0]; m_cnt[1] = n_cnt[1];
      end
   end

   always @(negedge aclk) begin
      bit gi, gd, blk, bi, bd;
      if (!aresetn) begin
         n_pend = 0; n_id = 0; n_addr = 0; n_size = 0;
         n_cnt[0] = 0; n_cnt[1] = 0;
      end else begin
         blk = bus.wr_busy && (bus.wr_addr[31:2] == bus.data_addr[31:2]);
         gd  = !m_pend && bus.data_req && (m_cnt[1] < MAX_OUT) && !blk;
         gi  = !m_pend && bus.inst_req && (m_cnt[0] < MAX_OUT) && !gd;
         bi  = bus.rvalid && (bus.rid == 4'd0);
         bd  = bus.rvalid && (bus.rid == 4'd1);
         if (checks_on) begin
            chk("arvalid", bus.arvalid, m_pend);
            if (m_pend) begin
               chk("arid", bus.arid, m_id);
               chk("araddr", bus.araddr, m_addr);
               chk("arsize", bus.arsize, m_size);
            end
            chk("inst_addr_ok", bus.inst_addr_ok, gi);
            chk("data_addr_ok", bus.data_addr_ok, gd);
            chk("rready", bus.rready, 1);
            chk("inst_data_ok", bus.inst_data_ok, bi);
            chk("data_data_ok", bus.data_data_ok, bd);
            chk("inst_rdata", bus.inst_rdata, bus.rdata);
            chk("data_rdata", bus.data_rdata, bus.rdata);
         end
         n_pend = m_pend; n_id = m_id; n_addr = m_addr; n_size = m_size;
         if (gd) begin
            n_pend = 1; n_id = 4'd1; n_addr = bus.data_addr; n_size = {1'b0, bus.data_size};
         end else if (gi) begin
            n_pend = 1; n_id = 4'd0; n_addr = bus.inst_addr; n_size = {1'b0, bus.inst_size};
         end else if (m_pend && bus.arready) begin
            n_pend = 0;
         end
         n_cnt[0] = m_cnt[0] + int'(gi) - int'(bi);
         n_cnt[1] = m_cnt[1] + int'(gd) - int'(bd);
         for (int k = 0; k < 2; k++) if (n_cnt[k] < 0) n_cnt[k] = 0;
      end
   end

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic beat(input logic [3:0] id, input logic [31:0] d);
      bus.rvalid = 1; bus.rid = id; bus.rdata = d;
      step();
      bus.rvalid = 0;
   endtask

   initial begin
      bus.inst_req = 0; bus.inst_addr = 0; bus.inst_size = 0;
      bus.data_req = 0; bus.data_addr = 0; bus.data_size = 0;
      bus.wr_busy = 0; bus.wr_addr = 0; bus.arready = 0;
      bus.rid = 0; bus.rdata = 0; bus.rvalid = 0;

      repeat (2) @(posedge aclk);
      #1;
      chk("rst_rready", bus.rready, 0);
      chk("rst_arvalid", bus.arvalid, 0);
      aresetn = 1;
      checks_on = 1;
      #2;
      chk("rst_arid", bus.arid, 0);
      chk("rst_araddr", bus.araddr, 0);
      chk("rst_arsize", bus.arsize, 0);
      chk("rst_rready_hi", bus.rready, 1);

      // Single fetch
      step();
      bus.inst_req = 1; bus.inst_addr = 32'h1C00_0000; bus.inst_size = 2;
      #2 chk("fetch_addr_ok", bus.inst_addr_ok, 1);
      step();
      bus.inst_req = 0; bus.arready = 1;
      #2;
      chk("fetch_arvalid", bus.arvalid, 1);
      chk("fetch_arid", bus.arid, 0);
      chk("fetch_araddr", bus.araddr, 32'h1C00_0000);
      chk("fetch_arsize", bus.arsize, 2);
      step();
      bus.arready = 0;
      bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h0280_0000;
      #2;
      chk("fetch_data_ok", bus.inst_data_ok, 1);
      chk("fetch_rdata", bus.inst_rdata, 32'h0280_0000);
      step();
      bus.rvalid = 0;

      // Simultaneous requests: load wins, fetch follows
      bus.inst_req = 1; bus.inst_addr = 32'h0000_0100; bus.inst_size = 2;
      bus.data_req = 1; bus.data_addr = 32'h0000_2000; bus.data_size = 1;
      #2;
      chk("prio_data_ok", bus.data_addr_ok, 1);
      chk("prio_inst_held", bus.inst_addr_ok, 0);
      step();
      bus.data_req = 0; bus.arready = 1;
      #2;
      chk("prio_arid", bus.arid, 1);
      chk("prio_no_grant_req", bus.inst_addr_ok, 0);
      step();
      bus.arready = 0;
      #2 chk("prio_inst_next", bus.inst_addr_ok, 1);
      step();
      bus.inst_req = 0; bus.arready = 1;
      #2 chk("prio_arid2", bus.arid, 0);
      step();
      bus.arready = 0;
      beat(1, 32'h1111_1111);
      beat(0, 32'h2222_2222);

      // Read-after-write hold
      bus.wr_busy = 1; bus.wr_addr = 32'h0000_1004;
      bus.data_req = 1; bus.data_addr = 32'h0000_1006; bus.data_size = 1;
      bus.inst_req = 1; bus.inst_addr = 32'h0000_0200;
      #2;
      chk("raw_load_blocked", bus.data_addr_ok, 0);
      chk("raw_fetch_ok", bus.inst_addr_ok, 1);
      step();
      bus.inst_req = 0; bus.arready = 1;
      step();
      bus.arready = 0; bus.wr_busy = 0;
      #2 chk("raw_load_released", bus.data_addr_ok, 1);
      step();
      bus.data_req = 0; bus.arready = 1;
      step();
      bus.arready = 0;
      beat(0, 32'h3333_3333);
      beat(1, 32'h4444_4444);

      // Outstanding limit
      bus.inst_req = 1; bus.inst_addr = 32'h0000_0300; bus.arready = 1;
      #2 chk("lim_g1", bus.inst_addr_ok, 1);
      step();
      step();
      #2 chk("lim_g2", bus.inst_addr_ok, 1);
      step();
      step();
      #2;
      chk("lim_withheld", bus.inst_addr_ok, 0);
      chk("model_cnt_pin", m_cnt[0], 2);
      step();
      bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h5555_5555;
      #2 chk("lim_withheld_beat", bus.inst_addr_ok, 0);
      step();
      bus.rvalid = 0;
      #2 chk("lim_g3", bus.inst_addr_ok, 1);
      step();
      bus.inst_req = 0;
      step();
      bus.arready = 0;
      beat(0, 32'h6666_6666);
      beat(0, 32'h7777_7777);

      // AR backpressure
      bus.data_req = 1; bus.data_addr = 32'hA5A5_A5A4; bus.data_size = 2;
      #2 chk("bp_addr_ok", bus.data_addr_ok, 1);
      step();
      bus.data_req = 0; bus.data_addr = 32'h0;
      for (int i = 0; i < 5; i++) begin
         #2;
         chk("bp_arvalid", bus.arvalid, 1);
         chk("bp_araddr", bus.araddr, 32'hA5A5_A5A4);
         chk("bp_arid", bus.arid, 1);
         step();
      end
      bus.arready = 1;
      step();
      bus.arready = 0;
      #2 chk("bp_idle", bus.arvalid, 0);
      step();
      beat(1, 32'h8888_8888);

      // Async reset while in REQ with one fetch outstanding
      bus.inst_req = 1; bus.inst_addr = 32'h0000_0080; bus.inst_size = 2;
      #2 chk("rst_fetch_ok", bus.inst_addr_ok, 1);
      step();
      bus.inst_req = 0;
      #1 aresetn = 0;
      #1;
      chk("rst_mid_arvalid", bus.arvalid, 0);
      chk("rst_mid_cnt", dut.u_inst_cnt.count, 0);
      step();
      step();
      aresetn = 1;
      bus.rvalid = 1; bus.rid = 0; bus.rdata = 32'h9999_9999;
      step();
      bus.rvalid = 0;
      #2;
      chk("stray_cnt", dut.u_inst_cnt.count, 0);
      chk("model_cnt_after_rst", m_cnt[0], 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step();
         bus.inst_req  = ($urandom_range(0, 2) != 0);
         bus.inst_addr = $urandom;
         bus.inst_size = 2'($urandom_range(0, 2));
         bus.data_req  = ($urandom_range(0, 2) != 0);
         bus.data_addr = $urandom;
         bus.data_size = 2'($urandom_range(0, 2));
         bus.wr_busy   = $urandom_range(0, 1);
         bus.wr_addr   = ($urandom_range(0, 1) != 0) ?
                         {bus.data_addr[31:2], 2'($urandom)} : $urandom;
         bus.arready   = ($urandom_range(0, 2) != 0);
         bus.rvalid    = $urandom_range(0, 1);
         case ($urandom_range(0, 4))
            0, 1:    bus.rid = 4'd0;
            2, 3:    bus.rid = 4'd1;
            default: bus.rid = 4'($urandom_range(2, 15));
         endcase
         bus.rdata = $urandom;
      end
      step();
      bus.inst_req = 0; bus.data_req = 0; bus.rvalid = 0; bus.wr_busy = 0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Read-side scheduler between the core's two SRAM-like read requesters (instruction fetch, data load) and a single AXI AR/R channel pair. Grants one request at a time onto AR, tags it with a per-requester ID, bounds outstanding reads per requester, and routes R beats back by ID. Loads are held off while a pending store targets the same word, preserving read-after-write order against the write path.

## Interface
- MAX_OUT, 2: maximum outstanding reads per requester, 1..7.
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- inst_req  in  1  fetch read request.
- inst_addr  in  32  fetch address.
- inst_size  in  2  fetch size (0=byte, 1=half, 2=word).
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch data returned this cycle.
- inst_rdata  out  32  fetch data.
- data_req  in  1  load read request.
- data_addr  in  32  load address.
- data_size  in  2  load size.
- data_addr_ok  out  1  load request accepted this cycle.
- data_data_ok  out  1  load data returned this cycle.
- data_rdata  out  32  load data.
- wr_busy  in  1  write path holds an uncompleted store.
- wr_addr  in  32  address of that store.
- arid  out  4  AR ID.
- araddr  out  32  AR address.
- arsize  out  3  AR size.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  4  R ID.
- rdata  in  32  R data.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

The block drives no other AXI fields. Top level ties arlen=0, arburst=1, arlock=0, arcache=0, arprot=0.

## Operation
- AR FSM states are IDLE and REQ.
- IDLE: grant when an eligible requester exists. Latch addr, size and ID, pulse that requester's addr_ok, go to REQ.
- REQ: arvalid=1 with latched payload held stable. On arready, go to IDLE.
- Priority is fixed: data over inst.
- A requester is eligible when its req=1 and its outstanding count < MAX_OUT.
- A load is additionally blocked when wr_busy=1 and wr_addr[31:2]==data_addr[31:2]. While a load is blocked, a concurrent fetch may be granted.
- No grant in REQ. Both addr_ok outputs are 0 outside IDLE.
- ID encoding: inst=0, data=1. arsize={1'b0,size}.
- Outstanding counter per ID:
  - +1 on that requester's addr_ok.
  - −1 on rvalid&rready with matching rid.
  - Both events in the same cycle leave the count unchanged.
  - Count never exceeds MAX_OUT.
- rready=1 whenever out of reset.
- R routing:
  - rvalid with rid=0 → inst_data_ok=1, inst_rdata=rdata.
  - rvalid with rid=1 → data_data_ok=1, data_rdata=rdata.
  - Any other rid is consumed and ignored; counters unaffected.
  - rdata is passed through to both rdata outputs unconditionally.
- Same-ID responses are in AXI order, so no reorder buffer.
- Reset: state=IDLE, counters=0, latched payload=0. All outputs 0 except rdata passthroughs. Reset mid-transaction drops in-flight reads; no replay.

## Timing
- addr_ok is combinational in the IDLE cycle where req is seen.
- arvalid rises the next cycle.
- Minimum AR spacing is 2 cycles (IDLE, REQ).
- data_ok/rdata are combinational from rvalid in the same cycle (zero added latency).
- Counter update is visible on the next cycle. A requester at MAX_OUT receiving its final beat is eligible again the following cycle.
- arvalid, once high, stays high with a stable payload until arready. It is never withdrawn.

## Structure
- Shared package `axi_rd_pkg`: ID_INST=4'd0, ID_DATA=4'd1, AR FSM state enum, size-to-arsize width constants.
- Sub-module `rd_outstanding_cnt`: inputs inc, dec, param MAX; outputs count and full. Instantiated twice (inst, data).

## Test plan
- Single fetch: inst_req, addr=0x1C000000, size=2 → inst_addr_ok same cycle; next cycle arvalid, arid=0, araddr=0x1C000000, arsize=2. R beat rid=0, rdata=0x02800000 → inst_data_ok=1, inst_rdata=0x02800000.
- Simultaneous inst and data req in IDLE → data granted first (arid=1); fetch granted in the following IDLE cycle.
- RAW block: wr_busy=1, wr_addr=0x00001004, data_addr=0x00001006, plus inst_req → fetch granted, load stalled. Drop wr_busy → load granted next IDLE.
- Limit: MAX_OUT=2, three fetches with no R → third addr_ok withheld. One rid=0 beat → third granted one cycle later.
- Backpressure: arready low for 5 cycles → arvalid, araddr, arid stable throughout. Single handshake, then IDLE.
- Async reset asserted while in REQ with count=1 → arvalid=0 and counters=0 immediately. Stray rid=0 beat after reset is absorbed; count stays 0.
